// File: rtl/mux_arb_n.sv
// mux_arb_n: N-channel arbitrated mux (fixed priority / round-robin / forced select) with a registered output.
// Define MUX_ARB_LOCK_EN to hold the grant on one channel until it delivers a beat with in_last=1.
module mux_arb_n #(
  parameter int WIDTH = 32,
  parameter int CHANNELS = 4,
  parameter int SELW = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_last,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic                      force_en,
  input  logic [SELW-1:0]           force_sel,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_sel,
  output logic                      out_last,
  input  logic                      out_ready
);
  logic                load_en, any, xfer, g_last;
  logic [SELW-1:0]     rr_ptr, g, idx;
  logic [CHANNELS-1:0] elig, cand;
  logic [WIDTH-1:0]    g_data;
`ifdef MUX_ARB_LOCK_EN
  logic                lock;
  logic [SELW-1:0]     lock_ch;
`endif

  function automatic logic [SELW-1:0] wrap(input int v);
    return SELW'(v >= CHANNELS ? v - CHANNELS : v);
  endfunction

  // A one-hot shift past the top bit yields an empty set, so an out-of-range force_sel grants nothing.
`ifdef MUX_ARB_LOCK_EN
  assign elig = lock ? CHANNELS'(1) << lock_ch : force_en ? CHANNELS'(1) << force_sel : '1;
`else
  assign elig = force_en ? CHANNELS'(1) << force_sel : '1;
`endif
  assign cand    = elig & in_valid;
  assign load_en = !out_valid | out_ready;

  // Scan from farthest to nearest so the nearest candidate is the last assignment.
  always_comb begin
    g = '0;
    any = 1'b0;
    idx = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      idx = mode ? wrap(int'(rr_ptr) + k) : SELW'(k);
      if (cand[idx]) begin
        g = idx;
        any = 1'b1;
      end
    end
  end

  assign xfer     = any & load_en;
  assign in_ready = xfer ? CHANNELS'(1) << g : '0;
  assign g_data   = in_data[int'(g) * WIDTH +: WIDTH];
  assign g_last   = in_last[g];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      out_last  <= 1'b0;
      rr_ptr    <= '0;
`ifdef MUX_ARB_LOCK_EN
      lock      <= 1'b0;
      lock_ch   <= '0;
`endif
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= g_data;
        out_sel   <= g;
        out_last  <= g_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (xfer && mode && !force_en) rr_ptr <= wrap(int'(g) + 1);
`ifdef MUX_ARB_LOCK_EN
      if (xfer) begin
        lock    <= !g_last;
        lock_ch <= g;
      end
`endif
    end
  end
endmodule

// File: tb/tb_mux_arb_n.sv
// tb_mux_arb_n: table-driven directed test of mux_arb_n (4-channel main instance, 5-channel instance for out-of-range force).
module tb_mux_arb_n;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   in_valid, in_last, in_ready;
  logic [127:0] in_data;
  logic         mode, force_en, out_ready, out_valid, out_last;
  logic [1:0]   force_sel, out_sel;
  logic [31:0]  out_data;
  logic [4:0]   iv5, rdy5;
  logic [2:0]   fs5, sel5;
  logic [159:0] d5;
  logic         ov5, ol5;
  logic [31:0]  od5;
  logic [31:0]  ch [4];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] iv, il;
    logic       mode, fe;
    logic [1:0] fs;
    logic       ordy;
    logic [3:0] rdy;
    logic       ov;
    logic [1:0] sel;
    logic       last;
  } vec_t;
  vec_t v [19];

  always #5 clk = ~clk;

  mux_arb_n #(.WIDTH(32), .CHANNELS(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .mode(mode), .force_en(force_en), .force_sel(force_sel),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel), .out_last(out_last),
    .out_ready(out_ready)
  );

  mux_arb_n #(.WIDTH(32), .CHANNELS(5)) u5 (
    .clk(clk), .reset(reset), .in_valid(iv5), .in_data(d5), .in_last(5'b11111),
    .in_ready(rdy5), .mode(1'b0), .force_en(1'b1), .force_sel(fs5),
    .out_valid(ov5), .out_data(od5), .out_sel(sel5), .out_last(ol5), .out_ready(1'b1)
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", n, a, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] lsel [4];
    ch = '{32'h11110000, 32'h044100C3, 32'h22220002, 32'h00000065};
    //        iv       il       md    fe    fs     ordy  rdy      ov    sel    last
    v[0]  = '{4'b0001, 4'b1101, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
    v[1]  = '{4'b1010, 4'b0010, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1};
    v[2]  = '{4'b1010, 4'b1110, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1};
    v[3]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b1};
    v[4]  = '{4'b1111, 4'b0001, 1'b1, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
    v[5]  = '{4'b1111, 4'b0010, 1'b1, 1'b0, 2'd0, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1};
    v[6]  = '{4'b1111, 4'b0100, 1'b1, 1'b0, 2'd0, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1};
    v[7]  = '{4'b1111, 4'b1000, 1'b1, 1'b0, 2'd0, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1};
    v[8]  = '{4'b1111, 4'b0001, 1'b1, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
    v[9]  = '{4'b1111, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b1};
    v[10] = '{4'b1111, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b1};
    v[11] = '{4'b1111, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b1};
    v[12] = '{4'b1111, 4'b0010, 1'b1, 1'b0, 2'd0, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1};
    v[13] = '{4'b1111, 4'b0100, 1'b1, 1'b0, 2'd0, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1};
    v[14] = '{4'b1111, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1};
    v[15] = '{4'b1111, 4'b0100, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1};
    v[16] = '{4'b1101, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b1};
    v[17] = '{4'b1111, 4'b1000, 1'b1, 1'b0, 2'd0, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1};
    v[18] = '{4'b0110, 4'b0010, 1'b1, 1'b0, 2'd0, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1};
`ifdef MUX_ARB_LOCK_EN
    lsel = '{2'd0, 2'd0, 2'd0, 2'd1};
`else
    lsel = '{2'd0, 2'd1, 2'd0, 2'd1};
`endif
    in_valid = '0; in_last = '0; mode = 1'b0; force_en = 1'b0; force_sel = '0; out_ready = 1'b1;
    iv5 = '0; fs5 = '0; d5 = '0;
    in_data = {ch[3], ch[2], ch[1], ch[0]};
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", out_data, 32'd0);
    chk("reset out_sel", 32'(out_sel), 32'd0);
    chk("reset out_last", 32'(out_last), 32'd0);
    chk("reset idle in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 19; i++) begin
      in_valid = v[i].iv; in_last = v[i].il; mode = v[i].mode;
      force_en = v[i].fe; force_sel = v[i].fs; out_ready = v[i].ordy;
      #1;
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(v[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(v[i].ov));
      chk($sformatf("v%0d out_sel", i), 32'(out_sel), 32'(v[i].sel));
      chk($sformatf("v%0d out_data", i), out_data, ch[v[i].sel]);
      chk($sformatf("v%0d out_last", i), 32'(out_last), 32'(v[i].last));
      @(negedge clk);
    end
    // Packet from ch0 (last on its third beat) competing with ch1 under round-robin.
    for (int c = 0; c < 4; c++) begin
      in_valid = 4'b0011; in_last = (c == 2) ? 4'b0001 : 4'b0000;
      mode = 1'b1; force_en = 1'b0; out_ready = 1'b1;
      #1;
      chk($sformatf("lock%0d in_ready", c), 32'(in_ready), 32'(4'b0001 << lsel[c]));
      @(posedge clk);
      #1;
      chk($sformatf("lock%0d out_sel", c), 32'(out_sel), 32'(lsel[c]));
      chk($sformatf("lock%0d out_data", c), out_data, ch[lsel[c]]);
      chk($sformatf("lock%0d out_last", c), 32'(out_last), (c == 2) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    in_valid = 4'b1111;
    in_last = 4'b1111;
    reset = 1'b1;
    #1;
    chk("async reset out_valid", 32'(out_valid), 32'd0);
    chk("async reset out_data", out_data, 32'd0);
    chk("async reset out_sel", 32'(out_sel), 32'd0);
    @(posedge clk);
    #1;
    chk("held reset out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    iv5 = 5'b11111;
    for (int f = 0; f < 8; f++) begin
      fs5 = 3'(f);
      #1;
      chk($sformatf("ch5 force_sel=%0d in_ready", f), 32'(rdy5), (f < 5) ? 32'(5'b00001 << f) : 32'd0);
      @(negedge clk);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
